// File: rtl/fp_pkg.sv
// Shared floating-point format constants and tag-width helper for the
// dot-product accelerator's shared adder scheduling.
package fp_pkg;

  localparam int PARM_EXP  = 8;
  localparam int PARM_MANT = 23;
  localparam int FP_W      = 1 + PARM_EXP + PARM_MANT;

  // Width of a requester index; at least one bit so single-bit tags stay legal.
  function automatic int tag_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: combinational one-hot grant searching upward from a
// stored pointer with wrap. The pointer moves past the winner only on an
// enabled grant, so a blocked cycle leaves the priority order untouched.
module rr_arbiter
  import fp_pkg::*;
#(
  parameter int N = 4,
  localparam int TAG_W = tag_w(N)
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [N-1:0]     req_i,
  input  logic             en_i,
  output logic [N-1:0]     gnt_o,
  output logic [TAG_W-1:0] gnt_idx_o
);

  logic [TAG_W-1:0] ptr_q;
  logic             found;
  int               idx;

  // Pick the first requester at or after the pointer, wrapping past N-1.
  always_comb begin
    // NOTE: every output of a combinational block gets a default before any
    // conditional assignment; a path that skips an assignment infers a latch.
    gnt_o     = '0;
    gnt_idx_o = '0;
    found     = 1'b0;
    idx       = 0;
    if (en_i) begin
      for (int i = 0; i < N; i++) begin
        idx = (int'(ptr_q) + i) % N;
        if (!found && req_i[idx]) begin
          found      = 1'b1;
          gnt_o[idx] = 1'b1;
          gnt_idx_o  = TAG_W'(idx);
        end
      end
    end
  end

  // Advance the pointer one past the winner on every issued grant.
  always_ff @(posedge clk_i or posedge rst_i) begin
    // NOTE: state registers use non-blocking assignment so every flop samples
    // pre-edge values regardless of block evaluation order.
    if (rst_i) begin
      ptr_q <= '0;
    end else if (en_i && (|gnt_o)) begin
      ptr_q <= (gnt_idx_o == TAG_W'(N - 1)) ? '0 : gnt_idx_o + TAG_W'(1);
    end
  end

endmodule

// File: rtl/fp_add_scheduler.sv
// Shares one fixed-latency, stall-free pipelined FP adder among N_REQ
// requesters. A round-robin arbiter issues at most one operand pair per
// cycle; a tag shift register matched to the adder latency steers each sum
// back to its requester, and a counter tracks the operations in flight.
module fp_add_scheduler
  import fp_pkg::*;
#(
  parameter int N_REQ       = 4,
  parameter int PARM_EXP    = fp_pkg::PARM_EXP,
  parameter int PARM_MANT   = fp_pkg::PARM_MANT,
  parameter int ADD_LATENCY = 3,
  localparam int FP_W  = 1 + PARM_EXP + PARM_MANT,
  localparam int TAG_W = tag_w(N_REQ),
  localparam int CNT_W = $clog2(ADD_LATENCY + 1)
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  hold_i,
  input  logic [N_REQ-1:0]      req_valid_i,
  output logic [N_REQ-1:0]      req_ready_o,
  input  logic [N_REQ*FP_W-1:0] req_a_i,
  input  logic [N_REQ*FP_W-1:0] req_b_i,
  output logic                  add_valid_o,
  output logic [FP_W-1:0]       add_a_o,
  output logic [FP_W-1:0]       add_b_o,
  input  logic [FP_W-1:0]       add_result_i,
  output logic [N_REQ-1:0]      rsp_valid_o,
  output logic [FP_W-1:0]       rsp_data_o,
  output logic [CNT_W-1:0]      inflight_o,
  output logic                  busy_o
);

  // A single requester has nothing to share; refuse to elaborate.
  if (N_REQ < 2) begin : g_bad_n_req
    $error("fp_add_scheduler: N_REQ must be at least 2");
  end
  if (ADD_LATENCY < 1) begin : g_bad_latency
    $error("fp_add_scheduler: ADD_LATENCY must be at least 1");
  end

  logic [N_REQ-1:0] gnt;
  logic [TAG_W-1:0] gnt_idx;
  logic             arb_en;
  logic             last_vld;
  logic [TAG_W-1:0] last_tag;
  logic [CNT_W-1:0] cnt_q;

  // Nothing may be granted while held or while reset is asserted.
  assign arb_en = ~hold_i & ~rst_i;

  rr_arbiter #(.N(N_REQ)) u_arb (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .req_i     (req_valid_i),
    .en_i      (arb_en),
    .gnt_o     (gnt),
    .gnt_idx_o (gnt_idx)
  );

  assign req_ready_o = gnt;
  assign add_valid_o = |(req_valid_i & gnt);

  // Route the granted requester's operands to the adder; zero when idle.
  always_comb begin
    add_a_o = '0;
    add_b_o = '0;
    for (int k = 0; k < N_REQ; k++) begin
      if (gnt[k]) begin
        add_a_o = req_a_i[k*FP_W +: FP_W];
        add_b_o = req_b_i[k*FP_W +: FP_W];
      end
    end
  end

  // Tag pipeline: one {valid, tag} stage per adder cycle, never stalled.
  // Stage 0 loads every cycle, so hold cycles enter as bubbles.
  for (genvar s = 0; s < ADD_LATENCY; s++) begin : g_stage
    logic             vld_q;
    logic [TAG_W-1:0] tag_q;
    logic             vld_d;
    logic [TAG_W-1:0] tag_d;

    if (s == 0) begin : g_head
      assign vld_d = add_valid_o;
      assign tag_d = gnt_idx;
    end else begin : g_body
      assign vld_d = g_stage[s-1].vld_q;
      assign tag_d = g_stage[s-1].tag_q;
    end

    // Shift this stage; reset discards every in-flight tag.
    always_ff @(posedge clk_i or posedge rst_i) begin
      // NOTE: only the valid bits matter for correctness, but the tags are
      // cleared too so the whole pipeline is in a known state after reset.
      if (rst_i) begin
        vld_q <= 1'b0;
        tag_q <= '0;
      end else begin
        vld_q <= vld_d;
        tag_q <= tag_d;
      end
    end
  end

  assign last_vld = g_stage[ADD_LATENCY-1].vld_q;
  assign last_tag = g_stage[ADD_LATENCY-1].tag_q;

  // Decode the retiring tag into a one-hot strobe alongside the adder sum.
  always_comb begin
    rsp_valid_o = '0;
    rsp_data_o  = '0;
    if (last_vld) begin
      rsp_valid_o[last_tag] = 1'b1;
      rsp_data_o            = add_result_i;
    end
  end

  // Count issued-but-unretired operations; issue and retire together cancel.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else begin
      case ({add_valid_o, last_vld})
        2'b10:   cnt_q <= cnt_q + CNT_W'(1);
        2'b01:   cnt_q <= cnt_q - CNT_W'(1);
        default: cnt_q <= cnt_q;
      endcase
    end
  end

  assign inflight_o = cnt_q;
  assign busy_o     = (|req_valid_i) | (cnt_q != '0);

endmodule

// File: tb/tb_fp_add_scheduler.sv
// Scoreboard bench for fp_add_scheduler (N_REQ=4, ADD_LATENCY=3). The driver
// pushes the expected response for every expected grant; a negedge monitor
// pops and compares whenever a response strobe appears.
module tb_fp_add_scheduler;

  localparam int N   = 4;
  localparam int W   = 32;
  localparam int LAT = 3;

  typedef struct {
    logic [N-1:0] who;
    logic [W-1:0] data;
    int           due;
  } exp_t;

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic           hold = 1'b0;
  logic [N-1:0]   req_valid = '0;
  logic [N-1:0]   req_ready;
  logic [N*W-1:0] req_a = '0;
  logic [N*W-1:0] req_b = '0;
  logic           add_valid;
  logic [W-1:0]   add_a;
  logic [W-1:0]   add_b;
  logic [W-1:0]   add_result;
  logic [N-1:0]   rsp_valid;
  logic [W-1:0]   rsp_data;
  logic [1:0]     inflight;
  logic           busy;

  logic [W-1:0] a_tab [N];
  logic [W-1:0] b_tab [N];
  logic [W-1:0] adder_pipe [LAT];
  exp_t         sb [$];
  exp_t         mon_e;
  int           cyc = 0;
  int           n_checks = 0;
  int           n_err = 0;

  fp_add_scheduler #(.N_REQ(N), .ADD_LATENCY(LAT)) dut (
    .clk_i        (clk),
    .rst_i        (rst),
    .hold_i       (hold),
    .req_valid_i  (req_valid),
    .req_ready_o  (req_ready),
    .req_a_i      (req_a),
    .req_b_i      (req_b),
    .add_valid_o  (add_valid),
    .add_a_o      (add_a),
    .add_b_o      (add_b),
    .add_result_i (add_result),
    .rsp_valid_o  (rsp_valid),
    .rsp_data_o   (rsp_data),
    .inflight_o   (inflight),
    .busy_o       (busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Truncating positive-operand FP add: a deterministic stand-in for the
  // shared adder (1.0 + 2.0 gives 0x40400000).
  function automatic logic [W-1:0] fp_model(input logic [W-1:0] a, input logic [W-1:0] b);
    logic [W-1:0] x, y;
    logic [24:0]  mx, my, s;
    int           d;
    if (a[30:23] >= b[30:23]) begin x = a; y = b; end
    else begin x = b; y = a; end
    d  = int'(x[30:23]) - int'(y[30:23]);
    mx = {2'b01, x[22:0]};
    my = {2'b01, y[22:0]};
    my = (d > 24) ? '0 : (my >> d);
    s  = mx + my;
    if (s[24]) return {1'b0, x[30:23] + 8'd1, s[23:1]};
    return {1'b0, x[30:23], s[22:0]};
  endfunction

  // Adder environment model: fixed LAT-cycle pipeline, always computing.
  always @(posedge clk) begin
    adder_pipe[0] <= fp_model(add_a, add_b);
    for (int i = 1; i < LAT; i++) adder_pipe[i] <= adder_pipe[i-1];
  end
  assign add_result = adder_pipe[LAT-1];

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Drive one cycle of requests and check the issue side against hand values.
  task automatic step(input logic [N-1:0] v, input logic h, input logic [N-1:0] g);
    exp_t         e;
    logic [W-1:0] ea, eb;
    @(posedge clk);
    #1;
    req_valid = v;
    hold      = h;
    for (int k = 0; k < N; k++) begin
      req_a[k*W +: W] = a_tab[k];
      req_b[k*W +: W] = b_tab[k];
    end
    @(negedge clk);
    ea = '0;
    eb = '0;
    for (int k = 0; k < N; k++) begin
      if (g[k]) begin
        ea = a_tab[k];
        eb = b_tab[k];
      end
    end
    check("req_ready", W'(req_ready), W'(g));
    check("add_valid", W'(add_valid), W'(|g));
    check("add_a", add_a, ea);
    check("add_b", add_b, eb);
    if (g != '0) begin
      e.who  = g;
      e.data = fp_model(ea, eb);
      e.due  = cyc + LAT;
      sb.push_back(e);
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step('0, 1'b0, '0);
  endtask

  // Assert reset with the given requests pending; everything must stay quiet.
  task automatic do_reset(input logic [N-1:0] v);
    @(posedge clk);
    #1;
    rst       = 1'b1;
    req_valid = v;
    hold      = 1'b0;
    sb.delete();
    #1;
    check("rst_ready", W'(req_ready), '0);
    check("rst_add_valid", W'(add_valid), '0);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("rst_rsp_valid", W'(rsp_valid), '0);
      check("rst_rsp_data", rsp_data, '0);
      check("rst_inflight", W'(inflight), '0);
    end
    @(posedge clk);
    #1;
    rst       = 1'b0;
    req_valid = '0;
  endtask

  // Response monitor: every strobe must match the oldest expectation exactly
  // on its due cycle; an overdue expectation without a strobe is missing.
  always @(negedge clk) begin
    if (!rst) begin
      if (rsp_valid != '0) begin
        if (sb.size() == 0) begin
          check("rsp_unexpected", W'(rsp_valid), '0);
        end else begin
          mon_e = sb.pop_front();
          check("rsp_who", W'(rsp_valid), W'(mon_e.who));
          check("rsp_data", rsp_data, mon_e.data);
          check("rsp_cycle", W'(cyc), W'(mon_e.due));
        end
      end else if (sb.size() != 0 && sb[0].due <= cyc) begin
        check("rsp_missing", '0, W'(sb[0].who));
        void'(sb.pop_front());
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: bench did not finish, cycle %0d", cyc);
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [N-1:0] v;
    logic [N-1:0] g;
    logic         h;
    int           mptr;
    int           idx;
    int           wait_cnt [N];
    int           max_wait;

    for (int k = 0; k < N; k++) begin
      a_tab[k] = 32'h3F80_0000 + (k << 20);
      b_tab[k] = 32'h4000_0000 + (k << 18);
    end

    // Reset state.
    do_reset('0);

    // 1: single request from requester 2, 1.0 + 2.0.
    idle(4);
    a_tab[2] = 32'h3F80_0000;
    b_tab[2] = 32'h4000_0000;
    step(4'b0100, 1'b0, 4'b0100);
    step('0, 1'b0, '0);
    check("t1_inflight", W'(inflight), 32'd1);
    step('0, 1'b0, '0);
    step('0, 1'b0, '0);
    check("t1_rsp_valid", W'(rsp_valid), 32'h4);
    check("t1_rsp_data", rsp_data, 32'h4040_0000);
    idle(2);

    // 2: all four valid for 8 cycles from ptr 0.
    do_reset('0);
    for (int k = 0; k < N; k++) a_tab[k] = 32'h3F80_0000 + (k << 20);
    for (int i = 0; i < 8; i++) step(4'b1111, 1'b0, 4'(1 << (i % 4)));
    step('0, 1'b0, '0);
    check("t2_inflight_sat", W'(inflight), 32'd3);
    check("t2_busy", W'(busy), 32'd1);
    idle(3);
    check("t2_inflight_drain", W'(inflight), 32'd0);
    check("t2_idle_busy", W'(busy), 32'd0);

    // 3: requesters 1 and 3 with a two-cycle hold; ptr is 0 here.
    step(4'b1010, 1'b0, 4'b0010);
    step(4'b1010, 1'b0, 4'b1000);
    step(4'b1010, 1'b1, 4'b0000);
    check("t3_hold_busy", W'(busy), 32'd1);
    step(4'b1010, 1'b1, 4'b0000);
    step(4'b1010, 1'b0, 4'b0010);
    step(4'b1010, 1'b0, 4'b1000);
    idle(4);
    check("t3_inflight", W'(inflight), 32'd0);

    // 4: three ops in flight (ptr ends at 3), then reset discards them.
    step(4'b1111, 1'b0, 4'b0001);
    step(4'b1111, 1'b0, 4'b0010);
    step(4'b1111, 1'b0, 4'b0100);
    check("t4_inflight", W'(inflight), 32'd2);
    do_reset(4'b1111);
    step(4'b1111, 1'b0, 4'b0001);
    idle(4);

    // 5: requester 1 wins, requester 2 drops its request before a grant.
    step(4'b0110, 1'b0, 4'b0010);
    step(4'b0000, 1'b0, 4'b0000);
    idle(3);
    check("t5_inflight", W'(inflight), 32'd0);

    // 6: random valid/hold traffic against a round-robin reference.
    do_reset('0);
    v        = '0;
    mptr     = 0;
    max_wait = 0;
    for (int k = 0; k < N; k++) wait_cnt[k] = 0;
    for (int c = 0; c < 3000; c++) begin
      for (int k = 0; k < N; k++) begin
        if (!v[k] && $urandom_range(2) == 0) begin
          v[k]     = 1'b1;
          a_tab[k] = $urandom;
          b_tab[k] = $urandom;
        end else if (v[k] && $urandom_range(19) == 0) begin
          v[k]        = 1'b0;
          wait_cnt[k] = 0;
        end
      end
      h = ($urandom_range(4) == 0);
      g = '0;
      if (!h) begin
        for (int i = 0; i < N; i++) begin
          idx = (mptr + i) % N;
          if (g == '0 && v[idx]) g[idx] = 1'b1;
        end
      end
      step(v, h, g);
      if (g != '0) begin
        for (int k = 0; k < N; k++) begin
          if (g[k]) begin
            mptr        = (k + 1) % N;
            wait_cnt[k] = 0;
            v[k]        = 1'b0;
          end else if (v[k]) begin
            wait_cnt[k]++;
            if (wait_cnt[k] > max_wait) max_wait = wait_cnt[k];
          end
        end
      end
    end
    idle(LAT + 2);
    check("t6_starvation", W'(max_wait <= N - 1), 32'd1);
    check("t6_sb_empty", W'(sb.size()), 32'd0);
    check("t6_inflight", W'(inflight), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
